// File: rtl/hc595_scan_if.sv
// Host-side bundle for the 74HC595 scan controller: frame-buffer write port,
// blank control, the serial chain pins, and the controller state for checkers.
interface hc595_scan_if #(
    parameter int SEG_W = 8
);
    // wr_en is a one-cycle strobe with no back-pressure. The write is taken on
    // every clk edge where it is high, and the controller never stalls it.
    logic             wr_en;
    logic [2:0]       wr_addr;
    logic [SEG_W-1:0] wr_data;
    logic             blank;
    logic             shcp;
    logic             stcp;
    logic             ds;
    logic             oe;
    logic [1:0]       dbg_state;

    modport master (
        output wr_en, wr_addr, wr_data, blank,
        input  shcp, stcp, ds, oe, dbg_state
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, blank,
        output shcp, stcp, ds, oe, dbg_state
    );
endinterface

// File: rtl/hc595_scan_ctrl.sv
// Multiplexed seven-segment scan controller. Once per slot it serializes
// {~segments, one-hot-low select} into a 74HC595 chain and then latches it.
module hc595_scan_ctrl #(
    parameter int DIGITS      = 6,
    parameter int SEG_W       = 8,
    parameter int CLK_DIV     = 2,
    parameter int SCAN_CYCLES = 50000
) (
    input  logic         clk,
    input  logic         rst,
    hc595_scan_if.slave  bus
);
    localparam int TOTAL = SEG_W + DIGITS;
    localparam int TW    = $clog2(SCAN_CYCLES);
    localparam int DW    = $clog2(2 * CLK_DIV);
    localparam int BW    = $clog2(TOTAL);

    localparam logic [TW-1:0] TMAX  = TW'(SCAN_CYCLES - 1);
    localparam logic [DW-1:0] DMAX  = DW'(2 * CLK_DIV - 1);
    localparam logic [DW-1:0] DHALF = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BMAX  = BW'(TOTAL - 1);
    localparam logic [2:0]    IMAX  = 3'(DIGITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_LATCH} state_t;

    state_t           r_state;
    logic [TW-1:0]    r_timer;
    logic [SEG_W-1:0] r_buf [DIGITS];
    logic [2:0]       r_idx;
    logic [TOTAL-1:0] r_sh;
    logic [DW-1:0]    r_div;
    logic [BW-1:0]    r_bit;
    logic             r_shcp;
    logic             r_stcp;
    logic             r_oe;
    logic             r_started;

    logic             w_tick;
    logic             w_wr_ok;
    logic [DIGITS-1:0] w_sel;
    logic [TOTAL-1:0] w_word;

    assign w_tick  = (r_timer == TMAX);
    assign w_wr_ok = bus.wr_en && (int'(bus.wr_addr) < DIGITS);
    assign w_sel   = ~(DIGITS'(1) << r_idx);
    assign w_word  = {~r_buf[r_idx], w_sel};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= TMAX;
        end else begin
            r_timer <= w_tick ? '0 : r_timer + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) r_buf[i] <= '0;
        end else if (w_wr_ok) begin
            r_buf[bus.wr_addr] <= bus.wr_data;
        end
    end

    // The shift register shifts on every bit end, including the last one, so
    // it has drained to zero by LATCH and its MSB can drive ds directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sh      <= '0;
            r_div     <= '0;
            r_bit     <= '0;
            r_idx     <= '0;
            r_shcp    <= 1'b0;
            r_stcp    <= 1'b0;
            r_oe      <= 1'b1;
            r_started <= 1'b0;
        end else begin
            if (r_started) r_oe <= bus.blank;
            case (r_state)
                S_IDLE: begin
                    r_shcp <= 1'b0;
                    r_stcp <= 1'b0;
                    if (w_tick) r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_sh    <= w_word;
                    r_bit   <= '0;
                    r_div   <= '0;
                    r_shcp  <= 1'b0;
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (r_div == DMAX) begin
                        r_div  <= '0;
                        r_shcp <= 1'b0;
                        r_sh   <= {r_sh[TOTAL-2:0], 1'b0};
                        if (r_bit == BMAX) begin
                            r_stcp  <= 1'b1;
                            r_state <= S_LATCH;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                        if (r_div == DHALF) r_shcp <= 1'b1;
                    end
                end
                S_LATCH: begin
                    if (r_div == DHALF) begin
                        r_div     <= '0;
                        r_stcp    <= 1'b0;
                        r_started <= 1'b1;
                        r_oe      <= bus.blank;
                        r_idx     <= (r_idx == IMAX) ? '0 : r_idx + 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.shcp      = r_shcp;
    assign bus.stcp      = r_stcp;
    assign bus.ds        = r_sh[TOTAL-1];
    assign bus.oe        = r_oe;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_hc595_scan_ctrl.sv
// Randomized bench for hc595_scan_ctrl: a slot-level reference model queues the
// expected serial word per slot; a monitor rebuilds words from shcp/ds and checks.
module tb_hc595_scan_ctrl;
    localparam int DIGITS  = 6;
    localparam int SEG_W   = 8;
    localparam int D       = 2;
    localparam int SCAN    = 100;
    localparam int TOTAL   = SEG_W + DIGITS;
    localparam int LATCH_S = 2 + 2 * D * TOTAL;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hc595_scan_if #(.SEG_W(SEG_W)) bus ();

    hc595_scan_ctrl #(
        .DIGITS(DIGITS), .SEG_W(SEG_W), .CLK_DIV(D), .SCAN_CYCLES(SCAN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (slot level) ----------------
    logic [TOTAL-1:0] exp_q[$];
    logic [SEG_W-1:0] mbuf [DIGITS];
    int   cur      = 0;
    int   midx     = 0;
    int   inflight = -1;
    logic oe_exp   = 1'b1;

    function automatic logic [TOTAL-1:0] model_word(input logic [SEG_W-1:0] seg, input int dig);
        logic [DIGITS-1:0] sel;
        for (int i = 0; i < DIGITS; i++) sel[i] = (i == dig) ? 1'b0 : 1'b1;
        return {~seg, sel};
    endfunction

    // cur is the index of the cycle currently in progress; cycle 0 is the
    // first cycle after reset release, and slots repeat every SCAN cycles.
    always @(posedge clk) begin
        if (rst) begin
            cur = 0; midx = 0; inflight = -1; oe_exp = 1'b1;
            exp_q.delete();
            foreach (mbuf[i]) mbuf[i] = '0;
        end else begin
            if (cur % SCAN == 1) begin
                exp_q.push_back(model_word(mbuf[midx], midx));
                inflight = midx;
                midx = (midx + 1) % DIGITS;
            end
            if (bus.wr_en && int'(bus.wr_addr) < DIGITS) mbuf[bus.wr_addr] = bus.wr_data;
            if (cur >= LATCH_S + D - 1) oe_exp = bus.blank;
            cur++;
        end
    end

    // ---------------- monitor ----------------
    logic [TOTAL-1:0] cap       = '0;
    logic [TOTAL-1:0] last_word = '0;
    int   nbits     = 0;
    logic prev_shcp = 1'b0;
    logic prev_stcp = 1'b0;

    always @(negedge clk) begin
        int s;
        logic e_shcp, e_stcp;
        logic [TOTAL-1:0] w;
        if (rst) begin
            chk("rst_shcp", 32'(bus.shcp), 32'd0);
            chk("rst_stcp", 32'(bus.stcp), 32'd0);
            chk("rst_ds",   32'(bus.ds),   32'd0);
            chk("rst_oe",   32'(bus.oe),   32'd1);
            cap = '0; nbits = 0; prev_shcp = 1'b0; prev_stcp = 1'b0;
        end else begin
            s = cur % SCAN;
            e_shcp = (s >= 2 && s < LATCH_S && ((s - 2) % (2 * D)) >= D);
            e_stcp = (s >= LATCH_S && s < LATCH_S + D);
            chk("shcp", 32'(bus.shcp), 32'(e_shcp));
            chk("stcp", 32'(bus.stcp), 32'(e_stcp));
            chk("oe",   32'(bus.oe),   32'(oe_exp));
            if (s >= 2 && s < LATCH_S) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL ds_noexp: got ds=%0b expected a queued word at cycle %0d", bus.ds, cur);
                end else begin
                    w = exp_q[0];
                    chk("ds", 32'(bus.ds), 32'(w[TOTAL - 1 - (s - 2) / (2 * D)]));
                end
            end else if (e_stcp) begin
                chk("ds_latch", 32'(bus.ds), 32'd0);
            end
            if (bus.shcp && !prev_shcp) begin
                cap = {cap[TOTAL-2:0], bus.ds};
                nbits++;
            end
            if (bus.stcp && !prev_stcp) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL word_noexp: got %0h expected no latch at cycle %0d", cap, cur);
                end else begin
                    w = exp_q.pop_front();
                    chk("word", 32'(cap), 32'(w));
                    chk("nbits", 32'(nbits), 32'(TOTAL));
                end
                last_word = cap;
                cap = '0; nbits = 0;
            end
            prev_shcp = bus.shcp;
            prev_stcp = bus.stcp;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic write(input int addr, input logic [SEG_W-1:0] data);
        bus.wr_en = 1'b1; bus.wr_addr = 3'(addr); bus.wr_data = data;
        cyc(1);
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_slot(input int s, input int dig, input int budget);
        while (!((cur % SCAN) == s && (dig < 0 || inflight == dig)) && budget > 0) begin
            cyc(1);
            budget--;
        end
        if (budget == 0) begin
            checks++; failures++;
            $display("FAIL wait_slot: got timeout expected slot pos %0d digit %0d", s, dig);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish by 2 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.blank = 1'b0;
        rst = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            bus.wr_en   = 1'($urandom_range(0, 1));
            bus.wr_addr = 3'($urandom_range(0, 7));
            bus.wr_data = 8'($urandom);
            bus.blank   = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.blank = 1'b0;
        write(0, 8'h3F);

        cyc(SCAN);
        chk("first_word", 32'(last_word), 32'(14'b11000000_111110));
        cyc(6 * SCAN);

        write(6, 8'($urandom));
        write(7, 8'($urandom));
        wait_slot(30, 1, 1000);
        write(1, 8'h06);
        wait_slot(1, -1, 200);
        write(midx, 8'($urandom));
        cyc(7 * SCAN);

        bus.blank = 1'b1;
        cyc(3 * SCAN);
        bus.blank = 1'b0;
        cyc(SCAN);

        repeat (600) begin
            bus.wr_en   = ($urandom_range(0, 7) == 0);
            bus.wr_addr = 3'($urandom_range(0, 7));
            bus.wr_data = 8'($urandom);
            cyc(1);
        end
        bus.wr_en = 1'b0;
        cyc(2 * SCAN);

        // Reset lands in the high half of bit 5, while oe is already low.
        wait_slot(2 + 2 * D * 5 + D, -1, 200);
        rst = 1'b1;
        #1;
        chk("midrst_shcp",  32'(bus.shcp), 32'd0);
        chk("midrst_stcp",  32'(bus.stcp), 32'd0);
        chk("midrst_ds",    32'(bus.ds),   32'd0);
        chk("midrst_oe",    32'(bus.oe),   32'd1);
        chk("midrst_state", 32'(bus.dbg_state), 32'd0);
        cyc(3);
        rst = 1'b0;
        cyc(8 * SCAN);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
